ksa_mul_seq: RTL and testbench



---
 rtl/ksa_mul_seq_if.sv | 34 +++
 rtl/ksa_mul_seq.sv | 96 +++++++++
 tb/tb_ksa_mul_seq.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/ksa_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : ksa_mul_seq_if
//  Purpose  : Operand, adder and result bundle for the shift-add multiplier.
//  Revision : 1.0
// ============================================================================
interface ksa_mul_seq_if #(
    parameter int WIDTH = 32
);
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     in_a;
    logic [WIDTH-1:0]     in_b;
    logic [63:0]          add_a;
    logic [63:0]          add_b;
    logic [63:0]          add_sum;
    logic                 add_cout;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   out_p;
    logic                 out_ovf;

    // The multiplier is the slave; the environment (source, adder, sink) is the master.
    modport slave (
        input  in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        output in_ready, add_a, add_b, out_valid, out_p, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, add_sum, add_cout, out_ready,
        input  in_ready, add_a, add_b, out_valid, out_p, out_ovf
    );
endinterface
`default_nettype wire

// File: rtl/ksa_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : ksa_mul_seq
//  Purpose  : Iterative unsigned shift-add multiplier around an external
//             64-bit adder; WIDTH cycles per product, valid/ready on both sides.
//  Revision : 1.0
// ============================================================================
module ksa_mul_seq #(
    parameter int WIDTH = 32
) (
    input  wire          clk,
    input  wire          rst,
    ksa_mul_seq_if.slave bus
);
    localparam int              c_CNT_W = $clog2(WIDTH + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [63:0]        r_acc;
    logic [63:0]        r_mcand;
    logic [WIDTH-1:0]   r_mplr;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_ovf;
    logic               w_accept;

    assign w_accept = (r_state == c_IDLE) && bus.in_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_p     = '0;
        bus.out_ovf   = 1'b0;
        bus.add_a     = r_acc;
        bus.add_b     = r_mplr[0] ? r_mcand : 64'd0;
        case (r_state)
            c_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = c_RUN;
                end
            end
            c_RUN: begin
                if (r_cnt == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE: begin
                bus.out_valid = 1'b1;
                bus.out_p     = r_acc[2*WIDTH-1:0];
                bus.out_ovf   = r_ovf;
                if (bus.out_ready) begin
                    w_state_nxt = c_IDLE;
                end
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // No early exit: a zero multiplier still walks all WIDTH steps for fixed latency.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (w_accept) begin
            r_acc   <= '0;
            r_mcand <= {{(64-WIDTH){1'b0}}, bus.in_a};
            r_mplr  <= bus.in_b;
            r_cnt   <= '0;
            r_ovf   <= 1'b0;
        end else if (r_state == c_RUN) begin
            r_acc   <= bus.add_sum;
            r_ovf   <= r_ovf | bus.add_cout;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + 1'b1;
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_ksa_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ksa_mul_seq
//  Purpose  : Self-checking bench for ksa_mul_seq with a behavioural adder and
//             partial-product reference model.
//  Revision : 1.0
// ============================================================================
module tb_ksa_mul_seq;
    localparam int c_WIDTH = 32;

    logic clk;
    logic rst;
    logic r_inject;
    int   total;
    int   bad;
    logic [64:0] w_full_sum;

    ksa_mul_seq_if #(.WIDTH(c_WIDTH)) bus ();

    ksa_mul_seq #(.WIDTH(c_WIDTH)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Ideal adder; r_inject forces a spurious carry-out to exercise the sticky flag.
    assign w_full_sum   = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign bus.add_sum  = w_full_sum[63:0];
    assign bus.add_cout = w_full_sum[64] | r_inject;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One full operation. hold = cycles of out_ready=0 after out_valid rises,
    // inj = RUN step at which a carry-out is injected (-1 for none),
    // poke = drive a bogus 7*7 request during RUN and DONE.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                          input int hold, input int inj, input bit poke);
        logic [63:0] exp_p;
        logic [63:0] exp_acc;
        logic [63:0] exp_addb;
        logic [63:0] mask;
        logic        exp_ovf;
        exp_p   = 64'(a) * 64'(b);
        exp_ovf = (inj >= 0);
        @(negedge clk);
        bus.out_ready = (hold == 0);
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_valid  = 1'b1;
        chk("idle_in_ready", 64'(bus.in_ready), 64'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        for (int i = 0; i < c_WIDTH; i++) begin
            @(negedge clk);
            mask     = (64'd1 << i) - 64'd1;
            exp_acc  = 64'(a) * (64'(b) & mask);
            exp_addb = b[i] ? (64'(a) << i) : 64'd0;
            chk("run_add_a", bus.add_a, exp_acc);
            chk("run_add_b", bus.add_b, exp_addb);
            chk("run_out_valid", 64'(bus.out_valid), 64'd0);
            chk("run_in_ready", 64'(bus.in_ready), 64'd0);
            r_inject = (i == inj);
            if (poke && i == 5) begin
                bus.in_valid = 1'b1;
                bus.in_a     = 32'd7;
                bus.in_b     = 32'd7;
            end
        end
        @(negedge clk);
        r_inject = 1'b0;
        chk("done_out_valid", 64'(bus.out_valid), 64'd1);
        chk("done_out_p", 64'(bus.out_p), exp_p);
        chk("done_out_ovf", 64'(bus.out_ovf), 64'(exp_ovf));
        chk("done_in_ready", 64'(bus.in_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_out_valid", 64'(bus.out_valid), 64'd1);
            chk("hold_out_p", 64'(bus.out_p), exp_p);
            chk("hold_in_ready", 64'(bus.in_ready), 64'd0);
        end
        bus.out_ready = 1'b1;
        @(negedge clk);
        chk("xfer_out_valid", 64'(bus.out_valid), 64'd0);
        chk("xfer_out_p", 64'(bus.out_p), 64'd0);
        chk("xfer_out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("xfer_in_ready", 64'(bus.in_ready), 64'd1);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("post_in_ready", 64'(bus.in_ready), 64'd1);
        chk("post_out_valid", 64'(bus.out_valid), 64'd0);
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        r_inject      = 1'b0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.out_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("rst_out_p", 64'(bus.out_p), 64'd0);
        chk("rst_out_ovf", 64'(bus.out_ovf), 64'd0);
        chk("rst_add_a", bus.add_a, 64'd0);
        chk("rst_add_b", bus.add_b, 64'd0);
        rst = 1'b0;

        run_op(32'd3, 32'd5, 0, -1, 1'b0);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, -1, 1'b0);
        run_op(32'h1234_5678, 32'd0, 0, -1, 1'b0);
        run_op(32'd0, 32'hFFFF_FFFF, 0, -1, 1'b0);
        run_op(32'hDEAD_BEEF, 32'h0000_1234, 10, -1, 1'b1);

        // Asynchronous reset mid-RUN, away from any clock edge.
        @(negedge clk);
        bus.in_a     = 32'hABCD_0123;
        bus.in_b     = 32'h0F0F_F0F1;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (11) @(negedge clk);
        chk("mid_run_add_b", bus.add_b, 64'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_out_valid", 64'(bus.out_valid), 64'd0);
        chk("arst_in_ready", 64'(bus.in_ready), 64'd1);
        chk("arst_add_a", bus.add_a, 64'd0);
        chk("arst_add_b", bus.add_b, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        chk("arst_release_in_ready", 64'(bus.in_ready), 64'd1);
        run_op(32'd6, 32'd7, 0, -1, 1'b0);

        run_op(32'd2, 32'd2, 0, 1, 1'b0);
        run_op(32'd9, 32'd11, 0, -1, 1'b0);

        for (int k = 0; k < 4; k++) begin
            run_op($urandom, $urandom, int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
`default_nettype wire
